// File: rtl/datamemory_pkg.sv
// Shared encodings for the byte-addressed data memory and its lane aligner.
package datamemory_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/datamemory_lane_align.sv
// Combinational byte-lane steering: store replication/enables and load extract/extend.
module datamemory_lane_align
    import datamemory_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_signed,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    // Replicating the data means the byte enables alone select the target lanes.
    always_comb begin
        st_be   = 4'b0000;
        st_data = '0;
        case (st_size)
            SIZE_BYTE: begin
                st_be   = 4'b0001 << st_lane;
                st_data = {4{st_wdata[7:0]}};
            end
            SIZE_HALF: begin
                st_be   = 4'b0011 << st_lane;
                st_data = {2{st_wdata[15:0]}};
            end
            SIZE_WORD: begin
                st_be   = 4'b1111;
                st_data = st_wdata;
            end
            default: begin
                st_be   = 4'b0000;
                st_data = '0;
            end
        endcase
    end

    always_comb begin
        ld_shifted = ld_word >> {ld_lane, 3'b000};
        case (ld_size)
            SIZE_BYTE: ld_data = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
            SIZE_HALF: ld_data = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
            default:   ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/datamemory_sized.sv
// Word-organised little-endian data memory with valid/ready requests,
// a LATENCY-deep response pipeline and a post-reset clear engine.
module datamemory_sized
    import datamemory_pkg::*;
#(
    parameter int ADDRWIDTH      = 32,
    parameter int DEPTH          = 2**14,
    parameter int WIDTH          = 32,
    parameter int LATENCY        = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter     LOADFROM       = "NONE"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [ADDRWIDTH-1:0] address,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 resp_valid,
    output logic [WIDTH-1:0]     data_out,
    output logic                 resp_error
);

    localparam int  AW       = $clog2(DEPTH);
    localparam bit  CLEAR_EN = (CLEAR_ON_RESET != 0) && (LOADFROM == "NONE");
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_idx;

    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic            out_of_range;
    logic            req_err;
    logic            accept;
    logic            store_en;
    logic [3:0]      st_be;
    logic [WIDTH-1:0] st_data;
    logic [WIDTH-1:0] ld_data;

    logic             vld_p   [LATENCY];
    logic             err_p   [LATENCY];
    logic             wr_p    [LATENCY];
    logic             sgn_p   [LATENCY];
    logic [1:0]       size_p  [LATENCY];
    logic [1:0]       lane_p  [LATENCY];
    logic [WIDTH-1:0] rdata_p [LATENCY];

    assign word_idx     = address[AW+1:2];
    assign lane         = address[1:0];
    assign out_of_range = |address[ADDRWIDTH-1:AW+2];
    assign req_err      = (req_size == SIZE_RSVD)
                       || ((req_size == SIZE_HALF) && address[0])
                       || ((req_size == SIZE_WORD) && (address[1:0] != 2'b00))
                       || out_of_range;
    assign accept       = req_valid && req_ready;
    assign store_en     = accept && req_write && !req_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= CLEAR_EN ? CLEAR : IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_idx == LAST_IDX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               clr_idx <= '0;
        else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end

    datamemory_lane_align u_align (
        .st_size   (req_size),
        .st_lane   (lane),
        .st_wdata  (data_in),
        .st_be     (st_be),
        .st_data   (st_data),
        .ld_size   (size_p[LATENCY-1]),
        .ld_lane   (lane_p[LATENCY-1]),
        .ld_signed (sgn_p[LATENCY-1]),
        .ld_word   (rdata_p[LATENCY-1]),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (store_en) begin
            for (int b = 0; b < 4; b++)
                if (st_be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
    end

    // Stage 0 captures the request and the pre-write word at the accept edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            err_p[0]   <= req_err;
            wr_p[0]    <= req_write;
            sgn_p[0]   <= req_signed;
            size_p[0]  <= req_size;
            lane_p[0]  <= lane;
            rdata_p[0] <= mem[word_idx];
        end
        for (int i = 1; i < LATENCY; i++) begin
            err_p[i]   <= err_p[i-1];
            wr_p[i]    <= wr_p[i-1];
            sgn_p[i]   <= sgn_p[i-1];
            size_p[i]  <= size_p[i-1];
            lane_p[i]  <= lane_p[i-1];
            rdata_p[i] <= rdata_p[i-1];
        end
    end

    // Final stage: outputs are forced to zero unless a response is present
    assign resp_valid = vld_p[LATENCY-1];
    assign resp_error = vld_p[LATENCY-1] && err_p[LATENCY-1];
    assign data_out   = (vld_p[LATENCY-1] && !err_p[LATENCY-1] && !wr_p[LATENCY-1])
                      ? ld_data : '0;

endmodule

// File: tb/tb_datamemory_sized.sv
// Directed and randomized checks of datamemory_sized against a byte-level reference model.
module tb_datamemory_sized;

    localparam int DEPTH = 16;
    localparam int LAT   = 3;
    localparam int NBYTE = 4 * DEPTH;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        resp_valid;
    logic [31:0] data_out;
    logic        resp_error;

    datamemory_sized #(
        .ADDRWIDTH      (32),
        .DEPTH          (DEPTH),
        .WIDTH          (32),
        .LATENCY        (LAT),
        .CLEAR_ON_RESET (1),
        .LOADFROM       ("NONE")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .address    (address),
        .data_in    (data_in),
        .resp_valid (resp_valid),
        .data_out   (data_out),
        .resp_error (resp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  mb [NBYTE];
    int          cyc;
    int          errors;
    int          checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] r, output logic e);
        int v;
        e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
            || (a >= 32'(NBYTE));
        r = 32'd0;
        if (!e) begin
            if (wr) begin
                mb[a] = d[7:0];
                if (sz != 2'd0) mb[a+1] = d[15:8];
                if (sz == 2'd2) begin
                    mb[a+2] = d[23:16];
                    mb[a+3] = d[31:24];
                end
            end else begin
                case (sz)
                    2'd0: begin
                        v = int'(mb[a]);
                        if (sg && v >= 128) v = v - 256;
                    end
                    2'd1: begin
                        v = int'(mb[a]) + int'(mb[a+1]) * 256;
                        if (sg && v >= 32768) v = v - 65536;
                    end
                    default: v = int'(mb[a]) + int'(mb[a+1]) * 256
                               + int'(mb[a+2]) * 65536 + int'(mb[a+3]) * 16777216;
                endcase
                r = 32'(v);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (expq.size() != 0 && expq[0].due == cyc) begin
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("data_out", data_out, expq[0].data);
            check("resp_error", 32'(resp_error), 32'(expq[0].err));
            void'(expq.pop_front());
        end else begin
            check("resp_valid_idle", 32'(resp_valid), 32'd0);
            check("data_out_idle", data_out, 32'd0);
            check("resp_error_idle", 32'(resp_error), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic req(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
        exp_t        x;
        logic [31:0] r;
        logic        e;
        check("req_ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        address    = a;
        data_in    = d;
        model(wr, sz, sg, a, d, r, e);
        x.due  = cyc + LAT;
        x.data = r;
        x.err  = e;
        expq.push_back(x);
        tick();
    endtask

    // Expects the clear engine to hold off requests for exactly DEPTH cycles.
    task automatic clear_phase();
        for (int i = 0; i < DEPTH; i++) begin
            check("clear_ready_low", 32'(req_ready), 32'd0);
            tick();
        end
        check("ready_after_clear", 32'(req_ready), 32'd1);
        for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
    endtask

    initial begin
        cyc        = 0;
        errors     = 0;
        checks     = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        address    = '0;
        data_in    = '0;
        for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;

        #2;
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_data_out", data_out, 32'd0);
        check("reset_resp_error", 32'(resp_error), 32'd0);
        check("reset_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        clear_phase();

        req(0, 2'd2, 0, 32'h3C, 32'h0);
        idle(LAT);
        check("after_clear_lw", data_out, 32'h0);

        req(1, 2'd2, 0, 32'h10, 32'h8081_8283);
        req(0, 2'd0, 1, 32'h10, 32'h0);
        req(0, 2'd0, 0, 32'h11, 32'h0);
        req(0, 2'd1, 1, 32'h12, 32'h0);
        req(0, 2'd1, 0, 32'h12, 32'h0);
        idle(LAT + 1);

        req(1, 2'd2, 0, 32'h20, 32'h1111_1111);
        req(1, 2'd0, 0, 32'h21, 32'h0000_00AA);
        req(0, 2'd2, 0, 32'h20, 32'h0);
        req(1, 2'd1, 0, 32'h22, 32'h0000_BEEF);
        req(0, 2'd2, 0, 32'h20, 32'h0);
        idle(LAT + 1);

        req(0, 2'd2, 0, 32'h02, 32'h0);
        req(0, 2'd1, 1, 32'h03, 32'h0);
        req(0, 2'd3, 0, 32'h00, 32'h0);
        req(0, 2'd2, 0, 32'(NBYTE), 32'h0);
        req(1, 2'd2, 0, 32'h22, 32'hDEAD_BEEF);
        req(1, 2'd3, 0, 32'h20, 32'hDEAD_BEEF);
        req(1, 2'd0, 0, 32'(NBYTE) + 32'h1, 32'hDEAD_BEEF);
        req(1, 2'd1, 0, 32'h21, 32'hDEAD_BEEF);
        req(0, 2'd2, 0, 32'h20, 32'h0);
        idle(LAT + 1);

        req(1, 2'd2, 0, 32'h30, 32'hCAFE_F00D);
        req(0, 2'd2, 0, 32'h30, 32'h0);
        idle(LAT + 1);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, NBYTE + 7));
            req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(LAT + 1);

        req(0, 2'd2, 0, 32'h10, 32'h0);
        req(0, 2'd2, 0, 32'h14, 32'h0);
        req_valid = 1'b0;
        reset     = 1'b1;
        expq.delete();
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("midclear_ready_low", 32'(req_ready), 32'd0);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_phase();
        req(0, 2'd2, 0, 32'h10, 32'h0);
        req(0, 2'd2, 0, 32'h3C, 32'h0);
        idle(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
